// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard control unit: FSM states, stall-reason
// codes and the hard-wired zero register index.
package hazard_pkg;

  typedef enum logic {
    RUN,
    LD_WAIT
  } hz_state_t;

  typedef enum logic [1:0] {
    SR_NONE  = 2'd0,
    SR_LOAD  = 2'd1,
    SR_MD    = 2'd2,
    SR_FLUSH = 2'd3
  } stall_reason_t;

  // $0 never carries a real dependency, so it is excluded from load-use matching.
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/md_busy_counter.sv
// Occupancy tracker for the multiply/divide unit: loads MD_LAT on an accepted
// start and counts down to zero; busy while nonzero.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);

  localparam int CW = $clog2(MD_LAT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CW'(MD_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_control_unit.sv
// ID-stage hazard controller: load-use FSM, mul/div structural and HI/LO
// stalls, branch/jump flush priority and a saturating stall counter.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             ex_mem_branch_taken,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic             id_md_start,
  input  logic             id_md_read,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             md_busy,
  output logic [1:0]       stall_reason,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int LCW = $clog2(LOAD_LAT + 1);

  hz_state_t     state_q, state_d;
  logic [LCW-1:0] ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  stall_reason_t reason;
  logic          ld_haz, md_haz, md_busy_int, md_accept;

  assign ld_haz = id_ex_mem_read
                & (id_ex_rt != REG_W'(REG_ZERO))
                & ((id_ex_rt == if_id_rs) | (if_id_uses_rt & (id_ex_rt == if_id_rt)));

  assign md_haz = md_busy_int & (id_md_start | id_md_read);

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    reason       = SR_NONE;
    md_accept    = 1'b0;

    if (reset) begin
      // Outputs stay quiet; the registers clear on this edge.
    end else if (ex_mem_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      reason       = SR_FLUSH;
      state_d      = RUN;
      ld_cnt_d     = '0;
    end else if (state_q == LD_WAIT) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_bubble = 1'b1;
      reason       = SR_LOAD;
      ld_cnt_d     = ld_cnt_q - LCW'(1);
      if (ld_cnt_q == LCW'(1)) begin
        state_d = RUN;
      end
    end else if (ld_haz) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_bubble = 1'b1;
      reason       = SR_LOAD;
      if (LOAD_LAT > 1) begin
        state_d  = LD_WAIT;
        ld_cnt_d = LCW'(LOAD_LAT - 1);
      end
    end else if (md_haz) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_bubble = 1'b1;
      reason       = SR_MD;
    end else begin
      // A stalled jump only flushes once it is no longer held in ID.
      if (id_jump | id_jr) begin
        if_id_flush = 1'b1;
        reason      = SR_FLUSH;
      end
      md_accept = id_md_start;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_hold && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      ld_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  md_busy_counter #(
    .MD_LAT (MD_LAT)
  ) u_md_busy_counter (
    .clk   (clk),
    .reset (reset),
    .start (md_accept),
    .busy  (md_busy_int)
  );

  assign stall_reason = reason;
  assign md_busy      = md_busy_int & ~reset;
  assign stall_cnt    = reset ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench: two hazard units (LOAD_LAT=3 and LOAD_LAT=1 with a 3-bit
// stall counter) share one stimulus stream and are checked against a spec model.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       mr, uses, br, jmp, jr, mds, mdr;
  logic [4:0] ex_rt, rs, rt;

  logic       ph0, ih0, fl0, bb0, mb0;
  logic [1:0] sr0;
  logic [31:0] cnt0;
  logic       ph1, ih1, fl1, bb1, mb1;
  logic [1:0] sr1;
  logic [2:0] cnt1;

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_W(5), .LOAD_LAT(3), .MD_LAT(4), .CNT_W(32)) u_dut0 (
    .clk(clk), .reset(reset), .id_ex_mem_read(mr), .id_ex_rt(ex_rt),
    .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rt(uses),
    .ex_mem_branch_taken(br), .id_jump(jmp), .id_jr(jr),
    .id_md_start(mds), .id_md_read(mdr),
    .pc_hold(ph0), .if_id_hold(ih0), .if_id_flush(fl0), .id_ex_bubble(bb0),
    .md_busy(mb0), .stall_reason(sr0), .stall_cnt(cnt0)
  );

  hazard_control_unit #(.REG_W(5), .LOAD_LAT(1), .MD_LAT(4), .CNT_W(3)) u_dut1 (
    .clk(clk), .reset(reset), .id_ex_mem_read(mr), .id_ex_rt(ex_rt),
    .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rt(uses),
    .ex_mem_branch_taken(br), .id_jump(jmp), .id_jr(jr),
    .id_md_start(mds), .id_md_read(mdr),
    .pc_hold(ph1), .if_id_hold(ih1), .if_id_flush(fl1), .id_ex_bubble(bb1),
    .md_busy(mb1), .stall_reason(sr1), .stall_cnt(cnt1)
  );

  typedef struct {
    int          inst;
    logic [6:0]  ctrl;   // {pc_hold, if_id_hold, if_id_flush, id_ex_bubble, md_busy, reason}
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  string       phase = "init";

  bit          m_ldw[2];
  int          m_ldc[2];
  int          m_md[2];
  logic [31:0] m_cnt[2];
  int          m_lat[2];
  logic [31:0] m_cmax[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ldh();
    return mr && (ex_rt != 5'd0) && ((ex_rt == rs) || (uses && (ex_rt == rt)));
  endfunction

  function automatic exp_t model_out(input int i);
    exp_t e;
    logic ph, ih, fl, bb;
    logic [1:0] r;
    bit busy, mdh;
    busy = (m_md[i] != 0);
    mdh  = busy && (mds || mdr);
    {ph, ih, fl, bb, r} = '0;
    if (reset) begin
      // everything quiet
    end else if (br) begin
      fl = 1; bb = 1; r = 2'd3;
    end else if (m_ldw[i] || model_ldh()) begin
      ph = 1; ih = 1; bb = 1; r = 2'd1;
    end else if (mdh) begin
      ph = 1; ih = 1; bb = 1; r = 2'd2;
    end else if (jmp || jr) begin
      fl = 1; r = 2'd3;
    end
    e.inst = i;
    e.ctrl = {ph, ih, fl, bb, busy && !reset, r};
    e.cnt  = reset ? 32'd0 : m_cnt[i];
    return e;
  endfunction

  task automatic model_adv(input int i, input logic ph);
    bit ldh, mdh, was_wait;
    ldh      = model_ldh();
    mdh      = (m_md[i] != 0) && (mds || mdr);
    was_wait = m_ldw[i];
    if (reset) begin
      m_ldw[i] = 0; m_ldc[i] = 0; m_md[i] = 0; m_cnt[i] = '0;
      return;
    end
    if (ph && m_cnt[i] != m_cmax[i]) m_cnt[i] = m_cnt[i] + 1;
    if (mds && !br && !was_wait && !ldh && !mdh) m_md[i] = 4;
    else if (m_md[i] != 0) m_md[i] = m_md[i] - 1;
    if (br) begin
      m_ldw[i] = 0; m_ldc[i] = 0;
    end else if (was_wait) begin
      if (m_ldc[i] == 1) m_ldw[i] = 0;
      m_ldc[i] = m_ldc[i] - 1;
    end else if (ldh && m_lat[i] > 1) begin
      m_ldw[i] = 1; m_ldc[i] = m_lat[i] - 1;
    end
  endtask

  // One pipeline cycle: expectations are queued while inputs are applied,
  // then popped and compared once outputs have settled.
  task automatic step();
    exp_t e;
    logic ph_exp[2];
    for (int i = 0; i < 2; i++) begin
      e = model_out(i);
      ph_exp[i] = e.ctrl[6];
      exp_q.push_back(e);
    end
    #2;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.inst == 0) begin
        check($sformatf("%s_ctrl0", phase), {ph0, ih0, fl0, bb0, mb0, sr0}, e.ctrl);
        check($sformatf("%s_cnt0", phase), cnt0, e.cnt);
      end else begin
        check($sformatf("%s_ctrl1", phase), {ph1, ih1, fl1, bb1, mb1, sr1}, e.ctrl);
        check($sformatf("%s_cnt1", phase), {29'd0, cnt1}, e.cnt);
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_adv(i, ph_exp[i]);
    @(negedge clk);
  endtask

  task automatic idle();
    mr = 0; ex_rt = 0; rs = 0; rt = 0; uses = 0;
    br = 0; jmp = 0; jr = 0; mds = 0; mdr = 0;
  endtask

  initial begin
    m_lat  = '{3, 1};
    m_cmax = '{32'hFFFF_FFFF, 32'd7};
    for (int i = 0; i < 2; i++) begin
      m_ldw[i] = 0; m_ldc[i] = 0; m_md[i] = 0; m_cnt[i] = '0;
    end
    idle();
    reset = 1;
    @(negedge clk);

    phase = "reset";
    step(); step();
    reset = 0;
    phase = "idle";
    step();

    // LW r8 then ADD rs=r8
    phase = "ld_rs";
    mr = 1; ex_rt = 8; rs = 8;
    step();
    mr = 0;
    step(); step(); step();
    check("ld_lat3_cnt", cnt0, 32'd3);
    check("ld_lat1_cnt", {29'd0, cnt1}, 32'd1);

    // rt dependency, then uses_rt=0 and $0 variants
    phase = "ld_rt";
    mr = 1; ex_rt = 8; rs = 3; rt = 8; uses = 1;
    step();
    mr = 0;
    step(); step(); step();
    phase = "ld_nouse";
    mr = 1; uses = 0;
    step();
    phase = "ld_r0";
    uses = 1; ex_rt = 0; rs = 0; rt = 0;
    step();
    check("no_stall_cnt0", cnt0, 32'd6);
    check("no_stall_cnt1", {29'd0, cnt1}, 32'd2);

    // branch resolves while LOAD_LAT=3 unit is waiting
    phase = "ld_branch";
    idle();
    mr = 1; ex_rt = 9; rs = 9;
    step();
    mr = 0; br = 1;
    step();
    br = 0;
    step(); step();
    check("branch_abort_cnt0", cnt0, 32'd7);

    // MULT accepted, MFLO on the next cycle
    phase = "md";
    idle();
    mds = 1;
    step();
    mds = 0; mdr = 1;
    for (int k = 0; k < 5; k++) step();
    mdr = 0;
    check("md_cnt0", cnt0, 32'd11);

    // JR whose rs is the load destination
    phase = "jr_ld";
    mr = 1; ex_rt = 10; rs = 10; jr = 1;
    step();
    mr = 0;
    step(); step(); step();
    idle();
    phase = "jump";
    jmp = 1;
    step();
    jmp = 0;
    check("sat_cnt1", {29'd0, cnt1}, 32'd7);

    // start blocked by a branch, then accepted and a branch flush mid-busy
    phase = "md_branch";
    mds = 1; br = 1;
    step();
    br = 0;
    step();
    mds = 0; br = 1;
    step();
    br = 0; mdr = 1;
    step(); step(); step(); step();
    idle();

    // reset while in LD_WAIT with the multiplier busy
    phase = "rst_mid";
    mds = 1;
    step();
    mds = 0; mr = 1; ex_rt = 8; rs = 8;
    step();
    reset = 1;
    #1;
    check("rst_pc_hold0", ph0, 1'b0);
    check("rst_md_busy0", mb0, 1'b0);
    step();
    reset = 0;
    idle();
    #1;
    check("post_rst_md_busy0", mb0, 1'b0);
    check("post_rst_cnt0", cnt0, 32'd0);
    check("post_rst_hold0", ph0, 1'b0);
    phase = "post_rst";
    step();

    // randomized traffic over a small register space
    phase = "rand";
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 59) == 0);
      mr    = ($urandom_range(0, 2) == 0);
      ex_rt = 5'($urandom_range(0, 3));
      rs    = 5'($urandom_range(0, 3));
      rt    = 5'($urandom_range(0, 3));
      uses  = 1'($urandom_range(0, 1));
      br    = ($urandom_range(0, 7) == 0);
      jmp   = ($urandom_range(0, 9) == 0);
      jr    = ($urandom_range(0, 9) == 0);
      mds   = ($urandom_range(0, 5) == 0);
      mdr   = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
